// File: rtl/tile_feeder.sv
// Tile feeder: pops one SIZE x SIZE byte tile from an upstream FIFO and streams it
// Latency: first skewed byte appears 3 cycles after the pop cycle; tile period 2*SIZE+2
// Backpressure: stall freezes the stream step and blanks row outputs; one pop per tile
//
// Byte packing: tile element [r][c] sits at fifo_dout[(r*SIZE+c)*8 +: 8];
// row_data byte for row r sits at row_data[r*8 +: 8].
module tile_feeder #(
  parameter int SIZE = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fifo_pop_rdy,
  output logic                     fifo_pop,
  input  logic [8*SIZE*SIZE-1:0]   fifo_dout,
  input  logic                     stall,
  output logic [8*SIZE-1:0]        row_data,
  output logic [SIZE-1:0]          row_valid,
  output logic                     busy,
  output logic                     tile_done,
  output logic [15:0]              tiles_fed
);

  localparam int TW = $clog2(2*SIZE);
  localparam logic [TW-1:0] T_LAST = TW'(2*SIZE-2);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    CAPT   = 2'd2,
    STREAM = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic [TW-1:0]            t_q, t_d;
  logic [8*SIZE*SIZE-1:0]   tile_q, tile_d;
  logic [15:0]              tiles_fed_q, tiles_fed_d;
  logic                     stream_go;

  // State, step counter, captured tile and tile count registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      t_q         <= '0;
      tile_q      <= '0;
      tiles_fed_q <= '0;
    end else begin
      state_q     <= state_d;
      t_q         <= t_d;
      tile_q      <= tile_d;
      tiles_fed_q <= tiles_fed_d;
    end
  end

  // Next-state logic plus pop request and end-of-tile pulse
  always_comb begin
    state_d     = state_q;
    t_d         = t_q;
    tile_d      = tile_q;
    tiles_fed_d = tiles_fed_q;
    fifo_pop    = 1'b0;
    tile_done   = 1'b0;
    case (state_q)
      IDLE: begin
        fifo_pop = fifo_pop_rdy;
        if (fifo_pop_rdy) state_d = FETCH;
      end
      // FIFO output register updates at the end of this cycle
      FETCH: state_d = CAPT;
      CAPT: begin
        tile_d  = fifo_dout;
        t_d     = '0;
        state_d = STREAM;
      end
      STREAM: begin
        if (!stall) begin
          if (t_q == T_LAST) begin
            tile_done   = 1'b1;
            tiles_fed_d = tiles_fed_q + 16'd1;
            state_d     = IDLE;
          end else begin
            t_d = t_q + TW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // A reset cycle must not issue a pop or report a completed tile
    if (rst) begin
      fifo_pop  = 1'b0;
      tile_done = 1'b0;
    end
  end

  assign busy      = (state_q != IDLE) && !rst;
  assign tiles_fed = tiles_fed_q;
  assign stream_go = (state_q == STREAM) && !stall && !rst;

  // Row r sees column t-r of its tile row: a diagonal wavefront across the array
  for (genvar r = 0; r < SIZE; r++) begin : g_row
    logic [TW:0]          col;     // t - r; wraps to a large value when t < r
    logic                 in_win;
    logic [8*SIZE-1:0]    row_vec;
    logic [7:0]           row_byte;

    assign col      = {1'b0, t_q} - (TW+1)'(r);
    assign in_win   = ({1'b0, t_q} >= (TW+1)'(r)) && (col < (TW+1)'(SIZE));
    assign row_vec  = tile_q[r*8*SIZE +: 8*SIZE];
    assign row_byte = 8'(row_vec >> {col, 3'b000});

    assign row_valid[r]       = stream_go && in_win;
    assign row_data[r*8 +: 8] = (stream_go && in_win) ? row_byte : 8'h00;
  end

endmodule

// File: doc/tile_feeder.md
TILE_FEEDER -- requirements
Module: tile_feeder

Interface
REQ-001 The module SHALL have parameter SIZE, default 2, giving the tile edge length (SIZE x SIZE bytes per tile, SIZE rows out).
REQ-002 The module SHALL have one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  the single clock; all state updates occur on its rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 fifo_pop_rdy  input  1  the upstream tile FIFO holds at least one tile.
REQ-006 fifo_pop  output  1  one-cycle pop request to the upstream tile FIFO.
REQ-007 fifo_dout  input  8 x SIZE x SIZE  the FIFO's registered output tile, valid the cycle after fifo_pop.
REQ-008 stall  input  1  the downstream systolic array cannot accept data this cycle.
REQ-009 row_data  output  8 x SIZE  skewed byte per array row.
REQ-010 row_valid  output  SIZE  per-row qualifier for row_data.
REQ-011 busy  output  1  high in any state other than IDLE.
REQ-012 tile_done  output  1  one-cycle pulse marking the final stream step of a tile.
REQ-013 tiles_fed  output  16  count of completed tiles since reset.

Function
REQ-014 The module SHALL implement the states IDLE, FETCH, CAPT and STREAM.
REQ-015 IDLE: fifo_pop = fifo_pop_rdy; when fifo_pop_rdy = 1, next state FETCH; otherwise stay in IDLE.
REQ-016 FETCH: fifo_pop = 0; next state CAPT unconditionally (the FIFO updates dout on this edge).
REQ-017 CAPT: the module SHALL register fifo_dout into tile_reg, clear the step counter t to 0, and advance to STREAM.
REQ-018 fifo_pop SHALL be 0 in every state except IDLE, so exactly one pop is issued per tile.
REQ-019 STREAM: t runs 0 .. 2*SIZE-2; the counter width is $clog2(2*SIZE).
REQ-020 STREAM, row r, stall = 0: row_data[r] = tile_reg[r][t-r] and row_valid[r] = 1 if 0 <= t-r < SIZE; otherwise row_data[r] = 0 and row_valid[r] = 0.
REQ-021 STREAM, stall = 1: t SHALL hold, row_valid SHALL be all 0, and row_data SHALL be 0.
REQ-022 STREAM, stall = 0 and t < 2*SIZE-2: t increments by one.
REQ-023 STREAM, stall = 0 and t = 2*SIZE-2: the module SHALL pulse tile_done = 1, increment tiles_fed (wrapping 0xFFFF -> 0), and go to IDLE.
REQ-024 In IDLE, FETCH and CAPT, row_data and row_valid SHALL be 0.
REQ-025 Outputs SHALL depend only on registered state, except fifo_pop (depends on fifo_pop_rdy) and the stall gating of row_valid, row_data and tile_done.
REQ-026 The stall input SHALL be ignored outside STREAM, and fifo_pop_rdy SHALL be ignored outside IDLE.
REQ-027 The minimum tile period SHALL be 2*SIZE+2 cycles (IDLE, FETCH, CAPT and 2*SIZE-1 STREAM steps).

Reset
REQ-028 A cycle with rst = 1 SHALL force state IDLE, t = 0, tile_reg = 0 and tiles_fed = 0, taking priority over all other inputs, including mid-FETCH, mid-CAPT and mid-STREAM.
REQ-029 During a cycle with rst = 1, fifo_pop, busy, tile_done and row_valid SHALL all be 0.
REQ-030 A tile interrupted by reset SHALL be discarded, not replayed; the FIFO pop already issued SHALL not be retried.

Verification
REQ-031 (SIZE = 2) Tile [[1,2],[3,4]], stall = 0, fifo_pop_rdy pulsed -> one fifo_pop cycle, then two cycles later, over three STREAM cycles: row_data[0] = 1, 2, 0 with row_valid[0] = 1, 1, 0; row_data[1] = 0, 3, 4 with row_valid[1] = 0, 1, 1; tile_done on the third cycle; tiles_fed = 1.
REQ-032 Same tile with stall = 1 for 2 cycles at t = 1 -> row_valid = 00 during the stall, then the sequence resumes at t = 1 unchanged; tile_done 2 cycles later than in REQ-031.
REQ-033 fifo_pop_rdy held high for 3 tiles -> exactly 3 fifo_pop pulses spaced 6 cycles apart; tiles_fed = 3; busy low only for the IDLE cycles.
REQ-034 fifo_pop_rdy = 0 for 20 cycles -> fifo_pop = 0, busy = 0 and row_valid = 0 throughout.
REQ-035 rst = 1 asserted at STREAM t = 1 -> the next cycle shows state IDLE, row_valid = 00, tiles_fed = 0, and no tile_done pulse.
REQ-036 tiles_fed preloaded via 65535 tiles (or forced) -> the next tile_done wraps tiles_fed to 0.
